// File: rtl/led_pattern_ctrl.sv
// Key-driven LED bank sequencer: OFF/LEFT/RIGHT/BLINK patterns, 4 speeds, pause.
// Ports: clk, rst_n, key_mode/key_speed/key_pause in; led (active-low), mode, speed, paused, step_pulse out. Optional macro: LED_DIM_EN.
module led_pattern_ctrl #(
  parameter int TICK_CYC = 12_500_000,
  parameter int DIM_DUTY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_speed,
  input  logic       key_pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused,
  output logic       step_pulse
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    BLINK = 2'd3
  } state_t;

  localparam int BW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [BW-1:0] BASE_MAX = BW'(TICK_CYC - 1);

  if (TICK_CYC < 1) begin : g_bad_tick
    $error("TICK_CYC must be at least 1");
  end
  if (DIM_DUTY < 0 || DIM_DUTY > 8) begin : g_bad_duty
    $error("DIM_DUTY must be 0..8");
  end

  state_t          state;
  logic [BW-1:0]   base_cnt;
  logic [1:0]      step_cnt;
  logic [2:0]      pos;
  logic            run;
  logic            step_last;
  logic [7:0]      pat;
  logic [7:0]      led_nxt;

  assign mode      = state;
  assign run       = (state != OFF) && !paused;
  assign step_last = (step_cnt == (2'd3 - speed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      speed      <= 2'd0;
      paused     <= 1'b0;
      pos        <= 3'd0;
      base_cnt   <= '0;
      step_cnt   <= 2'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (key_mode) begin
        unique case (state)
          OFF:   state <= LEFT;
          LEFT:  state <= RIGHT;
          RIGHT: state <= BLINK;
          BLINK: state <= OFF;
        endcase
        pos      <= 3'd0;
        base_cnt <= '0;
        step_cnt <= 2'd0;
        paused   <= 1'b0;
      end else if (key_speed && !key_pause) begin
        speed    <= speed + 2'd1;
        base_cnt <= '0;
        step_cnt <= 2'd0;
      end else begin
        // The pause toggle uses the pre-toggle state for counting,
        // so the pausing edge still counts and the resuming edge holds.
        if (key_pause && state != OFF) begin
          paused <= ~paused;
        end
        if (run) begin
          if (base_cnt == BASE_MAX) begin
            base_cnt <= '0;
            if (step_last) begin
              step_cnt   <= 2'd0;
              pos        <= pos + 3'd1;
              step_pulse <= 1'b1;
            end else begin
              step_cnt <= step_cnt + 2'd1;
            end
          end else begin
            base_cnt <= base_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pat = 8'hFF;
    unique case (state)
      OFF:   pat = 8'hFF;
      LEFT:  pat = ~(8'h01 << pos);
      RIGHT: pat = ~(8'h80 >> pos);
      BLINK: pat = pos[0] ? 8'hFF : 8'h00;
    endcase
  end

`ifdef LED_DIM_EN
  logic [2:0] pwm_cnt;
  logic       dim_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end

  assign dim_on  = ({1'b0, pwm_cnt} < 4'(DIM_DUTY));
  assign led_nxt = dim_on ? pat : 8'hFF;
`else
  assign led_nxt = pat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 8'hFF;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with TICK_CYC=4.
// Table-driven key vectors plus directed step-timing, pause and reset sequences.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_mode;
  logic       key_speed;
  logic       key_pause;
  logic [7:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;
  logic       step_pulse;

  int nchk = 0;
  int nerr = 0;

  led_pattern_ctrl #(
    .TICK_CYC(4),
    .DIM_DUTY(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_speed (key_speed),
    .key_pause (key_pause),
    .led       (led),
    .mode      (mode),
    .speed     (speed),
    .paused    (paused),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       km;
    logic       kp;
    logic       ks;
    int         idle;
    logic [1:0] e_mode;
    logic [1:0] e_speed;
    logic       e_paused;
    logic [7:0] e_led;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // With dimming, lit bits may legitimately read high on some cycles.
  function automatic logic led_ok(logic [7:0] exp);
`ifdef LED_DIM_EN
    return (led & exp) == exp;
`else
    return led == exp;
`endif
  endfunction

  task automatic check_led(string name, logic [7:0] exp);
    nchk++;
    if (!led_ok(exp)) begin
      nerr++;
      $display("FAIL %s: led %02h expected %02h", name, led, exp);
    end
  endtask

  task automatic pulse(logic km, logic kp, logic ks);
    key_mode  = km;
    key_pause = kp;
    key_speed = ks;
    tick();
    key_mode  = 1'b0;
    key_pause = 1'b0;
    key_speed = 1'b0;
  endtask

  task automatic do_reset();
    key_mode  = 1'b0;
    key_pause = 1'b0;
    key_speed = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Returns ticks until step_pulse is seen, or -1 on timeout.
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (step_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int bad;
    int lows;

    vt[0]  = '{0, 0, 0, 1, 2'd0, 2'd0, 0, 8'hFF};
    vt[1]  = '{0, 1, 0, 1, 2'd0, 2'd0, 0, 8'hFF};
    vt[2]  = '{0, 0, 1, 1, 2'd0, 2'd1, 0, 8'hFF};
    vt[3]  = '{0, 0, 1, 1, 2'd0, 2'd2, 0, 8'hFF};
    vt[4]  = '{0, 0, 1, 1, 2'd0, 2'd3, 0, 8'hFF};
    vt[5]  = '{0, 0, 1, 1, 2'd0, 2'd0, 0, 8'hFF};
    vt[6]  = '{1, 0, 0, 1, 2'd1, 2'd0, 0, 8'hFE};
    vt[7]  = '{0, 1, 0, 1, 2'd1, 2'd0, 1, 8'hFE};
    vt[8]  = '{1, 1, 1, 1, 2'd2, 2'd0, 0, 8'h7F};
    vt[9]  = '{1, 0, 0, 1, 2'd3, 2'd0, 0, 8'h00};
    vt[10] = '{1, 0, 0, 1, 2'd0, 2'd0, 0, 8'hFF};
    vt[11] = '{1, 0, 0, 1, 2'd1, 2'd0, 0, 8'hFE};
    vt[12] = '{0, 1, 1, 1, 2'd1, 2'd0, 1, 8'hFE};
    vt[13] = '{0, 1, 0, 1, 2'd1, 2'd0, 0, 8'hFE};
    vt[14] = '{1, 0, 0, 1, 2'd2, 2'd0, 0, 8'h7F};

    key_mode  = 1'b0;
    key_pause = 1'b0;
    key_speed = 1'b0;
    rst_n     = 1'b0;
    #12;
    check("rst_led", led, 8'hFF);
    check("rst_mode", mode, 2'd0);
    check("rst_speed", speed, 2'd0);
    check("rst_paused", paused, 1'b0);
    check("rst_step", step_pulse, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      pulse(vt[i].km, vt[i].kp, vt[i].ks);
      repeat (vt[i].idle) tick();
      check($sformatf("vec%0d_mode", i), mode, vt[i].e_mode);
      check($sformatf("vec%0d_speed", i), speed, vt[i].e_speed);
      check($sformatf("vec%0d_paused", i), paused, vt[i].e_paused);
      check_led($sformatf("vec%0d_led", i), vt[i].e_led);
    end

    // LEFT walk at speed 0: 16-clock period, led wraps back to FE.
    do_reset();
    pulse(1, 0, 0);
    check("left_mode", mode, 2'd1);
    check_led("left_led_lag", 8'hFF);
    for (int i = 0; i < 8; i++) begin
      wait_step(n);
      check($sformatf("left_per%0d", i), n, (i == 0) ? 16 : 15);
      tick();
      check($sformatf("left_spw%0d", i), step_pulse, 1'b0);
      check_led($sformatf("left_led%0d", i), ~(8'h01 << ((i + 1) % 8)));
    end

    // RIGHT at speed 3, then back to speed 0 keeping pos.
    do_reset();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check("right_speed3", speed, 2'd3);
    check_led("right_led0", 8'h7F);
    wait_step(n);
    check("right_per0", n, 4);
    tick();
    check_led("right_led1", 8'hBF);
    wait_step(n);
    check("right_per1", n, 3);
    tick();
    check_led("right_led2", 8'hDF);
    pulse(0, 0, 1);
    check("right_speed0", speed, 2'd0);
    wait_step(n);
    check("right_per_slow", n, 16);
    tick();
    check_led("right_led3", 8'hEF);

    // Pause at pos 3 in LEFT; resume finishes the remaining count.
    do_reset();
    pulse(1, 0, 0);
    for (int i = 0; i < 3; i++) wait_step(n);
    tick();
    check_led("pause_led", 8'hF7);
    pulse(0, 1, 0);
    check("pause_on", paused, 1'b1);
    bad = 0;
    repeat (100) begin
      tick();
      if (step_pulse || !led_ok(8'hF7)) bad++;
    end
    check("pause_hold", bad, 0);
    pulse(0, 1, 0);
    check("pause_off", paused, 1'b0);
    wait_step(n);
    check("pause_remain", n, 14);
    tick();
    check_led("pause_next", 8'hEF);

    // BLINK at speed 3, then asynchronous reset mid-step.
    do_reset();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    tick();
    check_led("blink_led0", 8'h00);
    wait_step(n);
    check("blink_per0", n, 3);
    tick();
    check_led("blink_led1", 8'hFF);
    wait_step(n);
    check("blink_per1", n, 3);
    tick();
    check_led("blink_led2", 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", led, 8'hFF);
    check("arst_mode", mode, 2'd0);
    check("arst_speed", speed, 2'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Lit bit behaviour: dimmed duty or steady low.
    do_reset();
    pulse(1, 0, 0);
    tick();
    lows = 0;
    bad  = 0;
    for (int i = 0; i < 8; i++) begin
      if (!led[0]) lows++;
      if (led[7:1] != 7'h7F) bad++;
      tick();
    end
`ifdef LED_DIM_EN
    check("dim_low_cnt", lows, 2);
`else
    check("steady_low_cnt", lows, 8);
`endif
    check("unlit_high", bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
